// File: rtl/washer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : washer_pkg
// Description : Shared types, default duties and request decoding for the
//               washer motor drive.
// Revision    : 1.0 - initial release
// ============================================================================
package washer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RAMP_UP = 3'd1,
    RUN     = 3'd2,
    RAMP_DN = 3'd3,
    DEAD    = 3'd4,
    BRAKE   = 3'd5
  } motor_state_t;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_WASH = 2'd1,
    MODE_SPIN = 2'd2
  } motor_mode_t;

  localparam int c_PWM_BITS_DEF  = 8;
  localparam int c_WASH_DUTY_DEF = 64;
  localparam int c_SPIN_DUTY_DEF = 200;

  // Both requests at once are contradictory and are treated as a stop.
  function automatic motor_mode_t decode_req(input logic wash, input logic spin);
    motor_mode_t mode;
    case ({wash, spin})
      2'b10:   mode = MODE_WASH;
      2'b01:   mode = MODE_SPIN;
      default: mode = MODE_NONE;
    endcase
    return mode;
  endfunction

endpackage
`default_nettype wire

// File: rtl/washer_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : washer_pwm_gen
// Description : Free-running PWM counter and comparator with a kill input
//               that forces the registered gate enable low.
// Revision    : 1.0 - initial release
// ============================================================================
module washer_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                kill,
  output logic                pwm_out
);

  logic [PWM_BITS-1:0] r_cnt;
  logic                r_pwm_out;

  // Counter wraps naturally at 2**PWM_BITS-1; output is high while cnt < duty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt     <= '0;
      r_pwm_out <= 1'b0;
    end else begin
      r_cnt     <= r_cnt + PWM_BITS'(1);
      r_pwm_out <= (r_cnt < duty) & ~kill;
    end
  end

  assign pwm_out = r_pwm_out;

endmodule
`default_nettype wire

// File: rtl/washer_motor_drive.sv
`default_nettype none
// ============================================================================
// Module      : washer_motor_drive
// Description : Converts wash/spin/fault level commands into a soft-started
//               PWM drive with timed wash reversal and dead-time braking.
// Revision    : 1.0 - initial release
// ============================================================================
module washer_motor_drive
  import washer_pkg::*;
#(
  parameter int PWM_BITS  = c_PWM_BITS_DEF,
  parameter int WASH_DUTY = c_WASH_DUTY_DEF,
  parameter int SPIN_DUTY = c_SPIN_DUTY_DEF,
  parameter int RAMP_DIV  = 2,
  parameter int AGITATE_T = 16,
  parameter int DEADTIME  = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic motor_wash,
  input  logic motor_spin,
  input  logic fault,
  output logic pwm_out,
  output logic dir_cw,
  output logic brake,
  output logic motor_busy,
  output logic at_speed
);

  // Counter widths; a width of at least 1 keeps degenerate settings legal.
  localparam int PRESC_W = (RAMP_DIV  > 1) ? $clog2(RAMP_DIV)  : 1;
  localparam int AGIT_W  = (AGITATE_T > 1) ? $clog2(AGITATE_T) : 1;
  localparam int DEAD_W  = (DEADTIME  > 1) ? $clog2(DEADTIME)  : 1;

  localparam logic [PRESC_W-1:0]  c_PRESC_LAST = PRESC_W'(RAMP_DIV - 1);
  localparam logic [AGIT_W-1:0]   c_AGIT_LAST  = AGIT_W'(AGITATE_T - 1);
  localparam logic [DEAD_W-1:0]   c_DEAD_LAST  = DEAD_W'(DEADTIME - 1);
  localparam logic [PWM_BITS-1:0] c_WASH_TGT   = PWM_BITS'(WASH_DUTY);
  localparam logic [PWM_BITS-1:0] c_SPIN_TGT   = PWM_BITS'(SPIN_DUTY);

  motor_state_t        r_state,    w_state_nxt;
  motor_mode_t         r_cur_mode, w_cur_mode_nxt;
  motor_mode_t         w_req_mode;
  logic [PWM_BITS-1:0] r_duty,     w_duty_nxt;
  logic [PWM_BITS-1:0] w_tgt;
  logic                r_dir_cw,   w_dir_cw_nxt;
  logic                r_rev_pend, w_rev_pend_nxt;
  logic [PRESC_W-1:0]  r_presc,    w_presc_nxt;
  logic [AGIT_W-1:0]   r_agit,     w_agit_nxt;
  logic [DEAD_W-1:0]   r_dead,     w_dead_nxt;
  logic                w_presc_wrap;

  assign w_req_mode   = decode_req(motor_wash, motor_spin);
  assign w_tgt        = (r_cur_mode == MODE_SPIN) ? c_SPIN_TGT : c_WASH_TGT;
  assign w_presc_wrap = (r_presc == c_PRESC_LAST);

  // State and datapath registers; reset drops straight to idle without a ramp.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_cur_mode <= MODE_NONE;
      r_duty     <= '0;
      r_dir_cw   <= 1'b1;
      r_rev_pend <= 1'b0;
      r_presc    <= '0;
      r_agit     <= '0;
      r_dead     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur_mode <= w_cur_mode_nxt;
      r_duty     <= w_duty_nxt;
      r_dir_cw   <= w_dir_cw_nxt;
      r_rev_pend <= w_rev_pend_nxt;
      r_presc    <= w_presc_nxt;
      r_agit     <= w_agit_nxt;
      r_dead     <= w_dead_nxt;
    end
  end

  // Next-state logic: fault preempts everything, otherwise sequence the ramps.
  always_comb begin
    w_state_nxt    = r_state;
    w_cur_mode_nxt = r_cur_mode;
    w_duty_nxt     = r_duty;
    w_dir_cw_nxt   = r_dir_cw;
    w_rev_pend_nxt = r_rev_pend;
    w_presc_nxt    = r_presc;
    w_agit_nxt     = r_agit;
    w_dead_nxt     = r_dead;

    if (fault) begin
      // Only path that may cut a nonzero duty abruptly.
      w_state_nxt    = BRAKE;
      w_duty_nxt     = '0;
      w_rev_pend_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_duty_nxt = '0;
          if (w_req_mode != MODE_NONE) begin
            w_state_nxt    = RAMP_UP;
            w_dir_cw_nxt   = 1'b1;
            w_cur_mode_nxt = w_req_mode;
            w_presc_nxt    = '0;
          end
        end

        RAMP_UP: begin
          if (w_req_mode != r_cur_mode) begin
            w_state_nxt = RAMP_DN;
            w_presc_nxt = '0;
          end else if (r_duty == w_tgt) begin
            w_state_nxt = RUN;
            w_agit_nxt  = '0;
          end else if (w_presc_wrap) begin
            w_presc_nxt = '0;
            if (r_duty < w_tgt) begin
              w_duty_nxt = r_duty + PWM_BITS'(1);
            end
          end else begin
            w_presc_nxt = r_presc + PRESC_W'(1);
          end
        end

        RUN: begin
          if (w_req_mode != r_cur_mode) begin
            w_state_nxt    = RAMP_DN;
            w_presc_nxt    = '0;
            w_rev_pend_nxt = 1'b0;
          end else if (r_cur_mode == MODE_WASH) begin
            // Agitation: after AGITATE_T clocks at speed, stop and reverse.
            if (r_agit == c_AGIT_LAST) begin
              w_state_nxt    = RAMP_DN;
              w_presc_nxt    = '0;
              w_rev_pend_nxt = 1'b1;
            end else begin
              w_agit_nxt = r_agit + AGIT_W'(1);
            end
          end
        end

        RAMP_DN: begin
          if (r_duty == '0) begin
            w_state_nxt = DEAD;
            w_dead_nxt  = '0;
          end else if (w_presc_wrap) begin
            w_presc_nxt = '0;
            w_duty_nxt  = r_duty - PWM_BITS'(1);
          end else begin
            w_presc_nxt = r_presc + PRESC_W'(1);
          end
        end

        DEAD: begin
          w_duty_nxt = '0;
          if (r_dead == c_DEAD_LAST) begin
            w_rev_pend_nxt = 1'b0;
            if (r_rev_pend && (w_req_mode == MODE_WASH)) begin
              w_dir_cw_nxt = ~r_dir_cw;
              w_state_nxt  = RAMP_UP;
              w_presc_nxt  = '0;
            end else if (w_req_mode != MODE_NONE) begin
              w_dir_cw_nxt   = 1'b1;
              w_cur_mode_nxt = w_req_mode;
              w_state_nxt    = RAMP_UP;
              w_presc_nxt    = '0;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_dead_nxt = r_dead + DEAD_W'(1);
          end
        end

        BRAKE: begin
          // Fault has cleared; serve a full dead time before any restart.
          w_duty_nxt  = '0;
          w_state_nxt = DEAD;
          w_dead_nxt  = '0;
        end

        default: begin
          w_state_nxt = IDLE;
          w_duty_nxt  = '0;
        end
      endcase
    end
  end

  washer_pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk     (clk),
    .rstn    (rstn),
    .duty    (r_duty),
    .kill    (fault),
    .pwm_out (pwm_out)
  );

  // Brake only in zero-duty states, so it can never overlap a PWM pulse.
  assign brake      = (r_state == DEAD) || (r_state == BRAKE);
  assign dir_cw     = r_dir_cw;
  assign motor_busy = (r_state != IDLE);
  assign at_speed   = (r_state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_washer_motor_drive.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_washer_motor_drive
// Description : Scoreboard bench for washer_motor_drive. Stimulus pushes the
//               expected status-edge events; a negedge monitor pops/compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_washer_motor_drive;

  localparam int EV_START   = 0;  // motor_busy rises
  localparam int EV_RUN     = 1;  // at_speed rises (len = ramp-up cycles)
  localparam int EV_RUN_END = 2;  // at_speed falls (len = run cycles)
  localparam int EV_BRK     = 3;  // brake rises (len = cycles since last event)
  localparam int EV_BRK_END = 4;  // brake falls (len = brake cycles)
  localparam int EV_IDLE    = 5;  // motor_busy falls

  typedef struct {
    int kind;
    int dir;   // -1 = don't care
    int len;   // -1 = don't care
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic motor_wash = 1'b0;
  logic motor_spin = 1'b0;
  logic fault = 1'b0;
  logic pwm_out, dir_cw, brake, motor_busy, at_speed;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  bit   mon_en = 1'b0;
  int   ev_count = 0;
  int   gap = 0;
  int   pwm_left = 0;
  int   pwm_ones = 0;
  logic p_as = 1'b0, p_brk = 1'b0, p_busy = 1'b0;

  always #5 clk = ~clk;

  washer_motor_drive dut (
    .clk        (clk),
    .rstn       (rstn),
    .motor_wash (motor_wash),
    .motor_spin (motor_spin),
    .fault      (fault),
    .pwm_out    (pwm_out),
    .dir_cw     (dir_cw),
    .brake      (brake),
    .motor_busy (motor_busy),
    .at_speed   (at_speed)
  );

  task automatic push(input int kind, input int dir, input int len);
    exp_t e;
    e.kind = kind; e.dir = dir; e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic push_period(input int dir);
    push(EV_RUN,     dir, 129);
    push(EV_RUN_END, -1,  16);
    push(EV_BRK,     -1,  129);
    push(EV_BRK_END, -1,  4);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic observe(input int kind);
    exp_t e;
    ev_count++;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d dir=%0d len=%0d, required no event",
               kind, dir_cw, gap);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (e.dir >= 0 && e.dir != int'(dir_cw)) ||
          (e.len >= 0 && e.len != gap)) begin
        n_fail++;
        $display("FAIL event_%0d: got kind=%0d dir=%0d len=%0d, required kind=%0d dir=%0d len=%0d",
                 ev_count, kind, dir_cw, gap, e.kind, e.dir, e.len);
      end
    end
    gap = 0;
  endtask

  // Monitor: sample on the falling edge, turn status edges into events.
  always @(negedge clk) begin
    if (mon_en) begin
      gap++;
      if (brake) begin
        n_tests++;
        if (pwm_out) begin
          n_fail++;
          $display("FAIL brake_overlap: pwm_out=1 with brake=1 at %0t, required pwm_out=0", $time);
        end
      end
      if (pwm_left > 0) begin
        pwm_left--;
        pwm_ones += int'(pwm_out);
      end
      if (p_as && !at_speed)      observe(EV_RUN_END);
      if (!p_brk && brake)        observe(EV_BRK);
      if (p_brk && !brake)        observe(EV_BRK_END);
      if (p_busy && !motor_busy)  observe(EV_IDLE);
      if (!p_busy && motor_busy)  observe(EV_START);
      if (!p_as && at_speed)      observe(EV_RUN);
      p_as   = at_speed;
      p_brk  = brake;
      p_busy = motor_busy;
    end
  end

  task automatic drain(input int budget, input string tag);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d events pending after %0d cycles, required 0",
               tag, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  initial begin
    int ev_saved;
    // Reset held with a wash request present.
    motor_wash = 1'b1;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pwm_out",    int'(pwm_out),    0);
    check("rst_dir_cw",     int'(dir_cw),     1);
    check("rst_brake",      int'(brake),      0);
    check("rst_motor_busy", int'(motor_busy), 0);
    check("rst_at_speed",   int'(at_speed),   0);

    // Wash: three full agitation periods, direction alternating.
    push(EV_START, 1, -1);
    push_period(1);
    push_period(0);
    push_period(1);
    push(EV_RUN, 0, 129);
    mon_en = 1'b1;
    rstn = 1'b1;
    drain(2000, "wash");

    // Switch to spin two clocks into a wash RUN.
    motor_wash = 1'b0;
    motor_spin = 1'b1;
    push(EV_RUN_END, -1, 2);
    push(EV_BRK,     -1, 129);
    push(EV_BRK_END, -1, 4);
    push(EV_RUN,      1, 401);
    drain(1000, "wash_to_spin");

    // Spin holds: no reversal, duty 200 of 256.
    ev_saved = ev_count;
    pwm_ones = 0;
    pwm_left = 256;
    repeat (5000) @(posedge clk);
    #1;
    check("spin_pwm_ones",  pwm_ones,         200);
    check("spin_no_events", ev_count,         ev_saved);
    check("spin_at_speed",  int'(at_speed),   1);
    check("spin_dir_cw",    int'(dir_cw),     1);

    // Fault pulse of three edges at full spin duty.
    push(EV_RUN_END, -1, -1);
    push(EV_BRK,     -1, 0);
    push(EV_BRK_END, -1, 7);
    push(EV_RUN,      1, 401);
    fault = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("fault_pwm_out", int'(pwm_out), 0);
    check("fault_brake",   int'(brake),   1);
    repeat (2) @(posedge clk);
    #1 fault = 1'b0;
    drain(1000, "fault");

    // Both requests in RUN act as a stop.
    motor_wash = 1'b1;
    push(EV_RUN_END, -1, 2);
    push(EV_BRK,     -1, 401);
    push(EV_BRK_END, -1, 4);
    push(EV_IDLE,    -1, 0);
    drain(1000, "both_stop");
    check("stop_motor_busy", int'(motor_busy), 0);
    check("stop_at_speed",   int'(at_speed),   0);
    check("stop_brake",      int'(brake),      0);
    check("stop_pwm_out",    int'(pwm_out),    0);
    check("stop_dir_cw",     int'(dir_cw),     1);

    motor_wash = 1'b0;
    motor_spin = 1'b0;
    ev_saved = ev_count;
    repeat (20) @(posedge clk);
    #1;
    check("idle_quiet", ev_count, ev_saved);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
